pic_ack_controller: RTL and testbench

Interrupt controller for the PIC datapath. It latches edge-triggered requests into IRR and applies the mask. It resolves priority in either fully nested or automatic-rotation mode, and runs the two-pulse INTA acknowledge sequence that moves the winner into ISR and emits the interrupt vector. It also services non-specific and automatic EOI. It sits between the request lines and the CPU-side INTA/vector bus.

---
 rtl/pic_ack_controller.sv | 172 +++++++++++++++++
 tb/tb_pic_ack_controller.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pic_ack_controller.sv
// 8-level interrupt controller: edge-latched IRR, IMR, nested or rotating
// priority, two-pulse INTA acknowledge with vector, non-specific and auto EOI.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   ir[7:0]              request lines (edge sensitive)
//   imr_we, imr_wdata    mask register write
//   vec_base[4:0]        vector bits [7:3]
//   rot, aeoi            rotation mode, automatic EOI
//   eoi, inta            non-specific EOI strobe, acknowledge strobe
//   int_out              registered interrupt request to CPU
//   vec, vec_valid       interrupt vector and its 1-cycle qualifier
//   irr, isr, imr        request, in-service and mask registers
module pic_ack_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ir,
  input  logic       imr_we,
  input  logic [7:0] imr_wdata,
  input  logic [4:0] vec_base,
  input  logic       rot,
  input  logic       aeoi,
  input  logic       eoi,
  input  logic       inta,
  output logic       int_out,
  output logic [7:0] vec,
  output logic       vec_valid,
  output logic [7:0] irr,
  output logic [7:0] isr,
  output logic [7:0] imr
);

  typedef enum logic {
    IDLE,
    WAIT2
  } state_t;

  state_t     state, state_n;
  logic [7:0] ir_q;
  logic [2:0] lp, lp_n;
  logic [2:0] lvl, lvl_n;
  logic       spur, spur_n;
  logic       int_n;
  logic [7:0] vec_n;
  logic       vv_n;
  logic [7:0] irr_n, isr_n, imr_n;

  logic [7:0] rise;
  logic [7:0] irr_clr;
  logic [7:0] isr_set, isr_clr;
  logic [3:0] cand_r, top_r;
  logic       cand_v, top_v;
  logic [2:0] cand, top;
  logic [2:0] rank_c, rank_t;
  logic       pend;

  // Highest-priority set bit of v, where level lp+1 is
  // highest and lp lowest. Returns {found, index}.
  function automatic logic [3:0] pick(
    input logic [7:0] v,
    input logic [2:0] lo
  );
    logic [3:0] r;
    logic [2:0] i;
    r = 4'b0;
    // Walk lowest to highest so the best hit is written last.
    for (int k = 7; k >= 0; k--) begin
      i = lo + 3'(k) + 3'd1;
      if (v[i]) r = {1'b1, i};
    end
    return r;
  endfunction

  assign rise   = ir & ~ir_q;
  assign cand_r = pick(irr & ~imr, lp);
  assign top_r  = pick(isr, lp);
  assign cand_v = cand_r[3];
  assign cand   = cand_r[2:0];
  assign top_v  = top_r[3];
  assign top    = top_r[2:0];

  // Distance below the highest-priority slot; smaller wins.
  assign rank_c = cand - lp - 3'd1;
  assign rank_t = top - lp - 3'd1;

  assign pend = cand_v && (!top_v || rank_c < rank_t);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ir_q      <= 8'h00;
      lp        <= 3'd7;
      lvl       <= 3'd7;
      spur      <= 1'b0;
      int_out   <= 1'b0;
      vec       <= 8'h00;
      vec_valid <= 1'b0;
      irr       <= 8'h00;
      isr       <= 8'h00;
      imr       <= 8'hFF;
    end else begin
      state     <= state_n;
      ir_q      <= ir;
      lp        <= lp_n;
      lvl       <= lvl_n;
      spur      <= spur_n;
      int_out   <= int_n;
      vec       <= vec_n;
      vec_valid <= vv_n;
      irr       <= irr_n;
      isr       <= isr_n;
      imr       <= imr_n;
    end
  end

  always_comb begin
    state_n = state;
    lp_n    = lp;
    lvl_n   = lvl;
    spur_n  = spur;
    int_n   = int_out;
    vec_n   = vec;
    vv_n    = 1'b0;
    irr_clr = 8'h00;
    isr_set = 8'h00;
    isr_clr = 8'h00;

    unique case (state)
      IDLE: begin
        int_n = pend;
        if (inta) begin
          if (pend) begin
            isr_set = 8'h01 << cand;
            irr_clr = 8'h01 << cand;
            lvl_n   = cand;
            spur_n  = 1'b0;
          end else begin
            lvl_n  = 3'd7;
            spur_n = 1'b1;
          end
          int_n   = 1'b0;
          state_n = WAIT2;
        end
      end
      WAIT2: begin
        int_n = 1'b0;
        if (inta) begin
          vec_n   = {vec_base, lvl};
          vv_n    = 1'b1;
          state_n = IDLE;
          if (aeoi && !spur) begin
            isr_clr = 8'h01 << lvl;
            if (rot) lp_n = lvl;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // EOI acts on the pre-update ISR and overrides an
    // auto-EOI rotation in the same cycle.
    if (eoi && top_v) begin
      isr_clr = isr_clr | (8'h01 << top);
      if (rot) lp_n = top;
    end

    irr_n = (irr | rise) & ~irr_clr;
    isr_n = (isr & ~isr_clr) | isr_set;
    imr_n = imr_we ? imr_wdata : imr;
  end

endmodule

// File: tb/tb_pic_ack_controller.sv
// Bench for pic_ack_controller: directed scenarios then random traffic,
// every cycle compared against a priority-position reference model.
module tb_pic_ack_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] ir;
  logic       imr_we;
  logic [7:0] imr_wdata;
  logic [4:0] vec_base;
  logic       rot;
  logic       aeoi;
  logic       eoi;
  logic       inta;
  logic       int_out;
  logic [7:0] vec;
  logic       vec_valid;
  logic [7:0] irr;
  logic [7:0] isr;
  logic [7:0] imr;

  int total = 0;
  int bad = 0;

  logic [7:0] m_irr, m_isr, m_imr, m_irq, m_vec;
  logic       m_int, m_vv, m_wait, m_spur;
  int         m_lp, m_lvl;

  always #5 clk = ~clk;

  pic_ack_controller dut (
    .clk(clk),
    .rst(rst),
    .ir(ir),
    .imr_we(imr_we),
    .imr_wdata(imr_wdata),
    .vec_base(vec_base),
    .rot(rot),
    .aeoi(aeoi),
    .eoi(eoi),
    .inta(inta),
    .int_out(int_out),
    .vec(vec),
    .vec_valid(vec_valid),
    .irr(irr),
    .isr(isr),
    .imr(imr)
  );

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Priority position p=0 is level lp+1 (highest), p=7 is lp.
  task automatic model_step();
    logic [7:0] n_irr, n_isr, n_vec;
    logic       n_int, n_vv, n_wait, n_spur;
    int         n_lp, n_lvl;
    int         cp, cl, tp, tl, b;
    logic       pend;
    if (rst) begin
      m_irr = 0; m_isr = 0; m_imr = 8'hFF; m_irq = 0;
      m_vec = 0; m_int = 0; m_vv = 0; m_wait = 0;
      m_spur = 0; m_lp = 7; m_lvl = 7;
      return;
    end
    cp = 8; cl = 0; tp = 8; tl = 0;
    for (int p = 0; p < 8; p++) begin
      b = (m_lp + 1 + p) % 8;
      if (cp == 8 && m_irr[b] && !m_imr[b]) begin
        cp = p; cl = b;
      end
      if (tp == 8 && m_isr[b]) begin
        tp = p; tl = b;
      end
    end
    pend = (cp < 8) && (cp < tp);
    n_irr = m_irr | (ir & ~m_irq);
    n_isr = m_isr;
    n_vec = m_vec;
    n_vv = 0;
    n_wait = m_wait;
    n_spur = m_spur;
    n_lp = m_lp;
    n_lvl = m_lvl;
    if (!m_wait) begin
      n_int = pend;
      if (inta) begin
        if (pend) begin
          n_isr[cl] = 1'b1;
          n_irr[cl] = 1'b0;
          n_lvl = cl;
          n_spur = 0;
        end else begin
          n_lvl = 7;
          n_spur = 1;
        end
        n_wait = 1;
        n_int = 0;
      end
    end else begin
      n_int = 0;
      if (inta) begin
        n_vec = {vec_base, 3'(m_lvl)};
        n_vv = 1;
        n_wait = 0;
        if (aeoi && !m_spur) begin
          n_isr[m_lvl] = 1'b0;
          if (rot) n_lp = m_lvl;
        end
      end
    end
    if (eoi && tp < 8) begin
      n_isr[tl] = 1'b0;
      if (rot) n_lp = tl;
    end
    m_irr = n_irr; m_isr = n_isr; m_vec = n_vec;
    m_int = n_int; m_vv = n_vv; m_wait = n_wait;
    m_spur = n_spur; m_lp = n_lp; m_lvl = n_lvl;
    m_irq = ir;
    if (imr_we) m_imr = imr_wdata;
  endtask

  // One clock: model advance, edge, compare, then drop strobes.
  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    chk("irr", irr, m_irr);
    chk("isr", isr, m_isr);
    chk("imr", imr, m_imr);
    chk("int_out", {7'b0, int_out}, {7'b0, m_int});
    chk("vec", vec, m_vec);
    chk("vec_valid", {7'b0, vec_valid}, {7'b0, m_vv});
    inta = 0; eoi = 0; imr_we = 0; rst = 0;
  endtask

  task automatic wr_imr(input logic [7:0] v);
    imr_we = 1; imr_wdata = v;
    cyc();
  endtask

  task automatic ack2();
    inta = 1; cyc();
    inta = 1; cyc();
  endtask

  initial begin
    rst = 1; ir = 0; imr_we = 0; imr_wdata = 0;
    vec_base = 5'h08; rot = 0; aeoi = 0;
    eoi = 0; inta = 0;
    #2;
    cyc();
    chk("rst_irr", irr, 8'h00);
    chk("rst_isr", isr, 8'h00);
    chk("rst_imr", imr, 8'hFF);
    chk("rst_int", {7'b0, int_out}, 8'h00);
    chk("rst_vv", {7'b0, vec_valid}, 8'h00);

    // Basic acknowledge
    wr_imr(8'h00);
    ir = 8'h08; cyc();
    chk("basic_irr", irr, 8'h08);
    cyc();
    chk("basic_int", {7'b0, int_out}, 8'h01);
    inta = 1; cyc();
    chk("basic_isr", isr, 8'h08);
    chk("basic_irr0", irr, 8'h00);
    chk("basic_int0", {7'b0, int_out}, 8'h00);
    inta = 1; cyc();
    chk("basic_vec", vec, 8'h43);
    chk("basic_vv", {7'b0, vec_valid}, 8'h01);
    cyc();
    chk("basic_vv_end", {7'b0, vec_valid}, 8'h00);
    chk("basic_vec_hold", vec, 8'h43);
    eoi = 1; cyc();
    chk("basic_eoi", isr, 8'h00);
    ir = 0; cyc();

    // Fully nested
    ir = 8'h04; cyc(); cyc();
    ack2();
    chk("fn_isr2", isr, 8'h04);
    ir = 8'h24; cyc(); cyc();
    chk("fn_ir5_blocked", {7'b0, int_out}, 8'h00);
    ir = 8'h26; cyc(); cyc();
    chk("fn_ir1_int", {7'b0, int_out}, 8'h01);
    ack2();
    chk("fn_isr6", isr, 8'h06);
    eoi = 1; cyc();
    chk("fn_eoi", isr, 8'h04);
    eoi = 1; cyc();
    cyc();
    ack2();
    chk("fn_ir5_vec", vec, 8'h45);
    eoi = 1; cyc();
    ir = 0; cyc();
    chk("fn_clean", isr | irr, 8'h00);

    // Rotation with automatic EOI
    rot = 1; aeoi = 1;
    ir = 8'h01; cyc(); cyc();
    ack2();
    chk("rot_aeoi", isr, 8'h00);
    ir = 8'h00; cyc();
    ir = 8'h09; cyc(); cyc();
    inta = 1; cyc();
    chk("rot_isr3", isr, 8'h08);
    inta = 1; cyc();
    chk("rot_vec3", {5'b0, vec[2:0]}, 8'h03);
    cyc();
    ack2();
    chk("rot_vec0", vec, 8'h40);
    rot = 0; aeoi = 0; ir = 0; cyc();

    // Spurious acknowledge
    inta = 1; cyc();
    chk("spur_isr", isr, 8'h00);
    inta = 1; cyc();
    chk("spur_vec", vec, 8'h47);

    // Masking
    wr_imr(8'h10);
    ir = 8'h10; cyc(); cyc();
    chk("mask_int", {7'b0, int_out}, 8'h00);
    chk("mask_irr", irr, 8'h10);
    wr_imr(8'h00);
    chk("mask_int_w1", {7'b0, int_out}, 8'h00);
    cyc();
    chk("mask_int_w2", {7'b0, int_out}, 8'h01);

    // Reset mid-sequence
    inta = 1; cyc();
    rst = 1; cyc();
    chk("mrst_isr", isr, 8'h00);
    chk("mrst_imr", imr, 8'hFF);
    chk("mrst_vec", vec, 8'h00);
    inta = 1; cyc();
    chk("mrst_no_vv", {7'b0, vec_valid}, 8'h00);
    cyc();
    chk("mrst_no_vv2", {7'b0, vec_valid}, 8'h00);
    ir = 0;

    // Random traffic
    for (int n = 0; n < 2000; n++) begin
      ir = 8'($urandom);
      if ($urandom_range(0, 3) != 0) ir = irr ^ ir & 8'($urandom);
      inta = ($urandom_range(0, 3) == 0);
      eoi = ($urandom_range(0, 5) == 0);
      imr_we = ($urandom_range(0, 15) == 0);
      imr_wdata = 8'($urandom) & 8'($urandom);
      vec_base = 5'($urandom);
      rot = 1'($urandom);
      aeoi = 1'($urandom);
      rst = ($urandom_range(0, 199) == 0);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
